// File: rtl/mest_pro_pkg.sv
// Shared definitions for the memory sequencer: FSM state encoding,
// parameter defaults and the legal WAIT_CYCLES range.
package mest_pro_pkg;

  localparam int ADDR_BITS_DEF   = 16;
  localparam int DATA_BITS_DEF   = 8;
  localparam int WAIT_CYCLES_DEF = 4;
  localparam int WAIT_MIN        = 1;
  localparam int WAIT_MAX        = 15;
  localparam int CNT_BITS        = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Out-of-range wait counts are pinned to the nearest legal value.
  function automatic int clamp_wait(input int w);
    if (w < WAIT_MIN) return WAIT_MIN;
    if (w > WAIT_MAX) return WAIT_MAX;
    return w;
  endfunction

  // States in which the memory strobes are asserted.
  function automatic logic is_active(input state_e s);
    return (s == ST_SETUP) || (s == ST_ACCESS) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/mest_pro_wait_cnt.sv
// Down-counter that times the ACCESS phase; saturates at zero rather than
// wrapping.
module mest_pro_wait_cnt
  import mest_pro_pkg::*;
#(
  parameter int W = CNT_BITS
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mest_pro_mem_seq.sv
// Main-memory access sequencer: IDLE -> SETUP -> ACCESS(xWAIT_CYCLES) -> HOLD
// -> DONE, with every strobe and status output registered.
module mest_pro_mem_seq
  import mest_pro_pkg::*;
#(
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic                 i_wr,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_clr_err,
  input  logic [DATA_BITS-1:0] i_mm_rdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DATA_BITS-1:0] o_rdata,
  output logic                 o_overrun,
  output logic [ADDR_BITS-1:0] o_mm_addr,
  output logic [DATA_BITS-1:0] o_mm_dat,
  output logic                 o_mm_select,
  output logic                 o_cs,
  output logic                 o_we
);

  localparam int                  WAIT_EFF = clamp_wait(WAIT_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(WAIT_EFF - 1);

  state_e               state_q,   state_d;
  logic                 wr_q,      wr_d;
  logic [ADDR_BITS-1:0] addr_q,    addr_d;
  logic [DATA_BITS-1:0] wdata_q,   wdata_d;
  logic [DATA_BITS-1:0] rdata_q,   rdata_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic                 cs_q,      cs_d;
  logic                 sel_q,     sel_d;
  logic                 we_q,      we_d;

  logic cnt_load;
  logic cnt_en;
  logic cnt_zero;

  mest_pro_wait_cnt #(
    .W(CNT_BITS)
  ) u_wait_cnt (
    .clk    (clk),
    .i_reset(i_reset),
    .load   (cnt_load),
    .en     (cnt_en),
    .value  (CNT_LOAD),
    .zero   (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    overrun_d = overrun_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_req) begin
          wr_d    = i_wr;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        cnt_load = 1'b1;
      end
      ST_ACCESS: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          if (!wr_q) begin
            rdata_d = i_mm_rdata;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A request landing mid-access is dropped but flagged; set beats clear.
    if (i_req && is_active(state_q)) begin
      overrun_d = 1'b1;
    end else if (i_clr_err) begin
      overrun_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    cs_d   = is_active(state_d);
    sel_d  = is_active(state_d);
    we_d   = (state_d == ST_ACCESS) && wr_d;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= 1'b0;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_overrun   = overrun_q;
  assign o_mm_addr   = addr_q;
  assign o_mm_dat    = wdata_q;
  assign o_mm_select = sel_q;
  assign o_cs        = cs_q;
  assign o_we        = we_q;

endmodule

// File: tb/tb_mest_pro_mem_seq.sv
// Directed bench for the memory sequencer: one instance with WAIT_CYCLES=4
// and one with WAIT_CYCLES=1, expected values worked out by hand.
module tb_mest_pro_mem_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req1, req2;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        clr;
  logic [7:0]  mm_rdata;

  logic        busy1, done1, ovr1, sel1, cs1, we1;
  logic [7:0]  rdata1, dat1;
  logic [15:0] maddr1;
  logic        busy2, done2, ovr2, sel2, cs2, we2;
  logic [7:0]  rdata2, dat2;
  logic [15:0] maddr2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mest_pro_mem_seq #(.ADDR_BITS(16), .DATA_BITS(8), .WAIT_CYCLES(4)) dut1 (
    .clk(clk), .i_reset(rst), .i_req(req1), .i_wr(wr), .i_addr(addr),
    .i_wdata(wdata), .i_clr_err(clr), .i_mm_rdata(mm_rdata),
    .o_busy(busy1), .o_done(done1), .o_rdata(rdata1), .o_overrun(ovr1),
    .o_mm_addr(maddr1), .o_mm_dat(dat1), .o_mm_select(sel1), .o_cs(cs1), .o_we(we1)
  );

  mest_pro_mem_seq #(.ADDR_BITS(16), .DATA_BITS(8), .WAIT_CYCLES(1)) dut2 (
    .clk(clk), .i_reset(rst), .i_req(req2), .i_wr(wr), .i_addr(addr),
    .i_wdata(wdata), .i_clr_err(clr), .i_mm_rdata(mm_rdata),
    .o_busy(busy2), .o_done(done2), .o_rdata(rdata2), .o_overrun(ovr2),
    .o_mm_addr(maddr2), .o_mm_dat(dat2), .o_mm_select(sel2), .o_cs(cs2), .o_we(we2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, tallying we/cs cycles and o_done pulses on one instance.
  task automatic observe(input bit use2, input int n, output int we_n,
                         output int cs_n, output int done_first, output int done_n);
    we_n = 0; cs_n = 0; done_first = -1; done_n = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (use2 ? we2 : we1) we_n++;
      if (use2 ? cs2 : cs1) cs_n++;
      if (use2 ? done2 : done1) begin
        done_n++;
        if (done_first < 0) done_first = k;
      end
    end
  endtask

  int we_n, cs_n, d_first, d_n;
  int d_edges[2];

  initial begin
    rst = 1'b1; req1 = 1'b1; req2 = 1'b0; wr = 1'b1;
    addr = 16'hBEEF; wdata = 8'h11; clr = 1'b0; mm_rdata = 8'h00;

    // Reset, with a request in the same cycle that must be discarded.
    tick();
    chk("rst_busy", busy1, 0);
    chk("rst_cs",   cs1, 0);
    chk("rst_addr", maddr1, 16'h0000);
    chk("rst_ovr",  ovr1, 0);
    rst = 1'b0; req1 = 1'b0;
    tick();
    chk("rst_req_discard", busy1, 0);
    $display("txn reset");

    // Write 0xA5 to 0x1234.
    req1 = 1'b1; wr = 1'b1; addr = 16'h1234; wdata = 8'hA5;
    tick();
    req1 = 1'b0;
    chk("wr_setup_cs",   cs1, 1);
    chk("wr_setup_sel",  sel1, 1);
    chk("wr_setup_we",   we1, 0);
    chk("wr_setup_busy", busy1, 1);
    chk("wr_setup_addr", maddr1, 16'h1234);
    chk("wr_setup_dat",  dat1, 8'hA5);
    observe(0, 6, we_n, cs_n, d_first, d_n);
    chk("wr_we_cycles", we_n, 4);
    chk("wr_cs_cycles", cs_n, 5);
    chk("wr_done_edge", d_first, 6);
    chk("wr_done_cnt",  d_n, 1);
    chk("wr_done_cs",   cs1, 0);
    chk("wr_done_sel",  sel1, 0);
    tick();
    chk("wr_idle_busy", busy1, 0);
    chk("wr_idle_done", done1, 0);
    chk("wr_idle_addr", maddr1, 16'h1234);
    chk("wr_idle_dat",  dat1, 8'hA5);
    chk("wr_rdata_held", rdata1, 8'h00);
    $display("txn write addr=1234 data=a5");

    // Read from 0x00FF returning 0x3C.
    req1 = 1'b1; wr = 1'b0; addr = 16'h00FF; mm_rdata = 8'h3C;
    tick();
    req1 = 1'b0;
    observe(0, 6, we_n, cs_n, d_first, d_n);
    chk("rd_we_cycles", we_n, 0);
    chk("rd_done_edge", d_first, 6);
    chk("rd_rdata",     rdata1, 8'h3C);
    tick();
    mm_rdata = 8'h00;
    chk("rd_rdata_hold", rdata1, 8'h3C);
    $display("txn read addr=00ff data=3c");

    // Back-to-back: request held high through the first DONE.
    req1 = 1'b1; wr = 1'b1; addr = 16'h5555; wdata = 8'h66;
    tick();
    d_n = 0; d_edges[0] = -1; d_edges[1] = -1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 7) begin
        req1 = 1'b0;
        chk("b2b_second_setup", cs1, 1);
      end
      if (done1) begin
        if (d_n < 2) d_edges[d_n] = k;
        d_n++;
      end
    end
    chk("b2b_done_cnt", d_n, 2);
    chk("b2b_done1",    d_edges[0], 6);
    chk("b2b_done_gap", d_edges[1] - d_edges[0], 7);
    chk("b2b_ovr",      ovr1, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("b2b_ovr_clr", ovr1, 0);
    $display("txn back-to-back");

    // Overrun during ACCESS, including set-wins-over-clear.
    req1 = 1'b1; wr = 1'b1; addr = 16'h0A0A; wdata = 8'h5A;
    tick();
    req1 = 1'b0;
    tick();
    req1 = 1'b1;
    tick();
    chk("ovr_set", ovr1, 1);
    clr = 1'b1;
    tick();
    req1 = 1'b0; clr = 1'b0;
    chk("ovr_set_wins", ovr1, 1);
    observe(0, 3, we_n, cs_n, d_first, d_n);
    chk("ovr_done_edge", d_first, 3);
    chk("ovr_addr_kept", maddr1, 16'h0A0A);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clr", ovr1, 0);
    $display("txn overrun");

    // Reset on the second ACCESS cycle of a read.
    req1 = 1'b1; wr = 1'b0; addr = 16'h4321; mm_rdata = 8'h77;
    tick();
    req1 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_cs",    cs1, 0);
    chk("abort_sel",   sel1, 0);
    chk("abort_we",    we1, 0);
    chk("abort_busy",  busy1, 0);
    chk("abort_rdata", rdata1, 8'h00);
    observe(0, 8, we_n, cs_n, d_first, d_n);
    chk("abort_no_done", d_n, 0);
    chk("abort_rdata_after", rdata1, 8'h00);
    mm_rdata = 8'h00;
    $display("txn reset-abort");

    // WAIT_CYCLES=1 instance.
    req2 = 1'b1; wr = 1'b1; addr = 16'hABCD; wdata = 8'h5A;
    tick();
    req2 = 1'b0;
    chk("w1_setup_addr", maddr2, 16'hABCD);
    observe(1, 5, we_n, cs_n, d_first, d_n);
    chk("w1_we_cycles", we_n, 1);
    chk("w1_done_edge", d_first, 3);
    chk("w1_done_cnt",  d_n, 1);
    $display("txn wait1 write");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
